// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequencer: FSM states,
// sweep direction and wrap-mode encodings.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/addr_sequencer_dwell_timer.sv
// Per-address hold timer: counts 0..limit, expire is high while count==limit.
// load captures a new limit and restarts; clear restarts with the held limit.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            limit <= '0;
        end else if (load) begin
            limit <= dwell;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == limit);

endmodule

// File: rtl/addr_sequencer.sv
// Bounded, stepped address generator with start/stop handshake, programmable
// range/step/direction, one-shot or wrapping sweeps and per-address dwell.
module addr_sequencer
    import addr_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   step,
    input  logic               dir,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   address,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    state_t           state;
    logic [WIDTH-1:0] lo_q, hi_q, step_q;
    logic             dir_q, mode_q;

    logic             accept;
    logic             expire;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] adv_addr, reload_addr;
    logic             boundary;

    assign accept = (state == IDLE) && start && (lo <= hi);

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .clear  (expire),
        .dwell  (dwell),
        .expire (expire)
    );

    // One extra bit catches carry-out (ascending) and borrow (descending).
    always_comb begin
        sum  = {1'b0, address} + {1'b0, step_q};
        diff = {1'b0, address} - {1'b0, step_q};
        if (dir_q == DIR_UP) begin
            adv_addr    = sum[WIDTH-1:0];
            reload_addr = lo_q;
            boundary    = sum[WIDTH] || (sum[WIDTH-1:0] > hi_q);
        end else begin
            adv_addr    = diff[WIDTH-1:0];
            reload_addr = hi_q;
            boundary    = diff[WIDTH] || (diff[WIDTH-1:0] < lo_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            address <= '0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= MODE_ONESHOT;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo_q    <= lo;
                        hi_q    <= hi;
                        step_q  <= (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
                        dir_q   <= dir;
                        mode_q  <= mode;
                        address <= (dir == DIR_DOWN) ? hi : lo;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (expire) begin
                        if (!boundary) begin
                            address <= adv_addr;
                        end else if (mode_q == MODE_WRAP) begin
                            address <= reload_addr;
                            wrap    <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addr_sequencer.md
# addr_sequencer

Parametrised address sequencer that generates a bounded, stepped address stream for walking instruction/data memories, e.g. display scan, memory dump, or test-pattern sweep in the multiple-cycle CPU. It runs under a start/stop handshake and supports a programmable range, step, direction, one-shot or continuous wrap mode, and a per-address dwell time. It replaces the fixed 4-bit free-running wrap counter used for memory stepping.

## Interface
- WIDTH, 4, address width in bits (≥2)
- DWELL_W, 8, width of the dwell count
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level sampled at clk; begins a sweep when idle
- stop  input  1  aborts a running sweep
- lo  input  WIDTH  lower bound, inclusive
- hi  input  WIDTH  upper bound, inclusive
- step  input  WIDTH  address increment; 0 is treated as 1
- dir  input  1  0 = ascending from lo, 1 = descending from hi
- mode  input  1  0 = one-shot, 1 = continuous wrap
- dwell  input  DWELL_W  each address is held for dwell+1 cycles
- address  output  WIDTH  current address
- busy  output  1  high while a sweep runs
- wrap  output  1  one-cycle pulse when the address reloads in continuous mode
- done  output  1  one-cycle pulse at the end of a sweep, or on a rejected start

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE with address=0 and busy=wrap=done=0.
- IDLE:
  - start=1 with lo≤hi: latch lo, hi, step, dir, mode and dwell; set address to lo (dir=0) or hi (dir=1); clear the dwell timer; go to RUN.
  - start=1 with lo>hi: reject. Stay in IDLE, pulse done, address unchanged.
- RUN:
  - busy=1.
  - The dwell timer counts 0..dwell. When it reaches dwell, the address advances and the timer clears.
  - Advance ascending: compute addr+step in WIDTH+1 bits. Boundary if the result exceeds hi or carries out.
  - Advance descending: compute addr−step in WIDTH+1 bits. Boundary if the result borrows or is below lo.
  - Boundary with mode=1: reload lo (asc) or hi (desc) and pulse wrap in the same cycle.
  - Boundary with mode=0: address holds its last valid value and the FSM goes to DONE.
  - stop=1: go to IDLE next edge, address holds, no done pulse. stop wins over a simultaneous boundary.
- DONE: lasts exactly one cycle with done=1 and busy=0, then returns to IDLE.
- start while in RUN or DONE is ignored.
- Input changes during RUN have no effect; only the latched copies are used.
- lo==hi: the single address is repeated (mode=1, wrap every dwell+1 cycles) or the sweep ends after one dwell (mode=0).

## Timing
- Start latency: start sampled at edge N; address = first value and busy=1 after edge N.
- Each address is visible for exactly dwell+1 cycles.
- Wrap: the wrap pulse coincides with the cycle in which the reloaded address is first visible.
- Done pulse: asserted in the cycle after the last address's dwell expires; busy drops at the same edge.
- Total one-shot sweep cycles = K·(dwell+1), where K = number of visited addresses; done follows on the next cycle.
- Asynchronous rst mid-sweep: all outputs return to reset values immediately, with no done or wrap pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package addr_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the direction constants DIR_UP/DIR_DOWN;
  - the mode constants MODE_ONESHOT/MODE_WRAP.
- One sub-module, dwell_timer (DWELL_W): load/clear inputs and an expire output that is high when count==dwell. The FSM and address arithmetic stay in addr_sequencer.

## Test plan
- WIDTH=4, lo=0, hi=15, step=1, dir=0, mode=1, dwell=0 → 0..15 then 0, wrap pulses in the cycle showing 0 after 15, busy stays 1.
- lo=3, hi=10, step=3, dir=0, mode=0, dwell=2 → 3,6,9 each held 3 cycles; done one cycle after the 9th; busy=0; address holds 9.
- lo=2, hi=9, step=4, dir=1, mode=1, dwell=0 → 9,5,(borrow/below lo) reload 9 with wrap; sequence 9,5,9,5…
- lo=8, hi=4, start=1 → done pulse, FSM stays IDLE, address unchanged, busy never asserts.
- step=0, lo=14, hi=15, mode=0 → 14,15 then done (step treated as 1; carry boundary at 15).
- Mid-sweep: stop and boundary in the same cycle → IDLE with no done. Separately, rst mid-sweep → address=0 and all flags 0 asynchronously.
